// File: rtl/pkg_gen_if.sv
// Packet stream bundle (valid/ready/last/keep) between pkg_gen and its sink.
interface pkg_gen_if #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] bits_data;
  logic [KEEP_W-1:0] bits_keep;
  logic              bits_last;

  modport master (output valid, output bits_data, output bits_keep, output bits_last, input ready);
  modport slave  (input valid, input bits_data, input bits_keep, input bits_last, output ready);
endinterface

// File: rtl/pkg_gen.sv
// Packet stream generator: sends pkt_num packets of pkt_beats beats with a programmable idle gap.
// Optional macro PKG_GEN_TIMESTAMP_EN adds a first-beat cycle timestamp in data[95:64].
module pkg_gen #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              io_start,
  input  logic [CNT_W-1:0]  io_pkt_num,
  input  logic [LEN_W-1:0]  io_pkt_beats,
  input  logic [KEEP_W-1:0] io_last_keep,
  input  logic [CNT_W-1:0]  io_gap_cycle,
  output logic              io_busy,
  output logic              io_done,
  output logic [CNT_W-1:0]  io_sent_pkts,
  pkg_gen_if.master         io_data_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [KEEP_W-1:0] KEEP_ALL  = {KEEP_W{1'b1}};
  localparam logic [KEEP_W-1:0] KEEP_NONE = {KEEP_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  pkt_num_q, pkt_num_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [KEEP_W-1:0] last_keep_q, last_keep_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic [LEN_W-1:0]  beat_idx_q, beat_idx_d;
  logic [CNT_W-1:0]  seq_q, seq_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [LEN_W-1:0]  beats_in_s;
  logic              fire_s;
  logic [CNT_W-1:0]  seq_inc_s;
  logic [CNT_W-1:0]  sent_inc_s;
  logic [LEN_W-1:0]  beat_inc_s;
  logic [CNT_W-1:0]  ts_now_s;

  function automatic logic [DATA_W-1:0] make_data(input logic [CNT_W-1:0] seq,
                                                  input logic [CNT_W-1:0] pkt,
                                                  input logic [CNT_W-1:0] ts);
    logic [DATA_W-1:0] d;
    d = DATA_ZERO;
    d[0 +: CNT_W]       = seq;
    d[CNT_W +: CNT_W]   = pkt;
    d[2*CNT_W +: CNT_W] = ts;
    return d;
  endfunction

  function automatic logic [KEEP_W-1:0] sel_keep(input logic is_last, input logic [KEEP_W-1:0] lk);
    return is_last ? lk : KEEP_ALL;
  endfunction

`ifdef PKG_GEN_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_q;

  // Free-running cycle counter; +1 gives its value in the cycle the loaded beat is presented.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= CNT_ZERO;
    end else begin
      ts_q <= ts_q + CNT_ONE;
    end
  end

  assign ts_now_s = ts_q + CNT_ONE;
`else
  assign ts_now_s = CNT_ZERO;
`endif

  assign beats_in_s = (io_pkt_beats == LEN_ZERO) ? LEN_ONE : io_pkt_beats;
  assign fire_s     = valid_q & io_data_out.ready;
  assign seq_inc_s  = seq_q + CNT_ONE;
  assign sent_inc_s = sent_q + CNT_ONE;
  assign beat_inc_s = beat_idx_q + LEN_ONE;

  // Next-state and next-beat computation; output beats are staged one cycle ahead.
  always_comb begin
    state_d     = state_q;
    pkt_num_d   = pkt_num_q;
    beats_d     = beats_q;
    last_keep_d = last_keep_q;
    gap_d       = gap_q;
    sent_d      = sent_q;
    beat_idx_d  = beat_idx_q;
    seq_d       = seq_q;
    gap_cnt_d   = gap_cnt_q;
    valid_d     = valid_q;
    data_d      = data_q;
    keep_d      = keep_q;
    last_d      = last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (io_start) begin
          pkt_num_d   = io_pkt_num;
          beats_d     = beats_in_s;
          last_keep_d = io_last_keep;
          gap_d       = io_gap_cycle;
          sent_d      = CNT_ZERO;
          beat_idx_d  = LEN_ZERO;
          seq_d       = CNT_ZERO;
          busy_d      = 1'b1;
          if (io_pkt_num == CNT_ZERO) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SEND;
            valid_d = 1'b1;
            data_d  = make_data(CNT_ZERO, CNT_ZERO, ts_now_s);
            last_d  = (beats_in_s == LEN_ONE);
            keep_d  = sel_keep(beats_in_s == LEN_ONE, io_last_keep);
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_SEND: begin
        if (fire_s) begin
          seq_d = seq_inc_s;
          if (last_q) begin
            sent_d     = sent_inc_s;
            beat_idx_d = LEN_ZERO;
            if (sent_inc_s == pkt_num_q) begin
              state_d = ST_FIN;
              done_d  = 1'b1;
              valid_d = 1'b0;
              data_d  = DATA_ZERO;
              keep_d  = KEEP_NONE;
              last_d  = 1'b0;
            end else if (gap_q == CNT_ZERO) begin
              data_d = make_data(seq_inc_s, sent_inc_s, ts_now_s);
              last_d = (beats_q == LEN_ONE);
              keep_d = sel_keep(beats_q == LEN_ONE, last_keep_q);
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
              valid_d   = 1'b0;
              data_d    = DATA_ZERO;
              keep_d    = KEEP_NONE;
              last_d    = 1'b0;
            end
          end else begin
            beat_idx_d = beat_inc_s;
            data_d     = make_data(seq_inc_s, sent_q, CNT_ZERO);
            last_d     = (beat_inc_s == beats_q - LEN_ONE);
            keep_d     = sel_keep(beat_inc_s == beats_q - LEN_ONE, last_keep_q);
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        // Counting down to 1 makes the valid-low stretch exactly gap_cycle cycles.
        if (gap_cnt_q <= CNT_ONE) begin
          state_d = ST_SEND;
          valid_d = 1'b1;
          data_d  = make_data(seq_q, sent_q, ts_now_s);
          last_d  = (beats_q == LEN_ONE);
          keep_d  = sel_keep(beats_q == LEN_ONE, last_keep_q);
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_ONE;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and registered stream outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pkt_num_q   <= CNT_ZERO;
      beats_q     <= LEN_ONE;
      last_keep_q <= KEEP_NONE;
      gap_q       <= CNT_ZERO;
      sent_q      <= CNT_ZERO;
      beat_idx_q  <= LEN_ZERO;
      seq_q       <= CNT_ZERO;
      gap_cnt_q   <= CNT_ZERO;
      valid_q     <= 1'b0;
      data_q      <= DATA_ZERO;
      keep_q      <= KEEP_NONE;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_num_q   <= pkt_num_d;
      beats_q     <= beats_d;
      last_keep_q <= last_keep_d;
      gap_q       <= gap_d;
      sent_q      <= sent_d;
      beat_idx_q  <= beat_idx_d;
      seq_q       <= seq_d;
      gap_cnt_q   <= gap_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign io_busy               = busy_q;
  assign io_done               = done_q;
  assign io_sent_pkts          = sent_q;
  assign io_data_out.valid     = valid_q;
  assign io_data_out.bits_data = data_q;
  assign io_data_out.bits_keep = keep_q;
  assign io_data_out.bits_last = last_q;

endmodule

// File: tb/tb_pkg_gen.sv
// Scoreboard bench for pkg_gen: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_pkg_gen;
  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 32;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    bit                first;
  } beat_t;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              io_start = 1'b0;
  logic [CNT_W-1:0]  io_pkt_num = '0;
  logic [LEN_W-1:0]  io_pkt_beats = '0;
  logic [KEEP_W-1:0] io_last_keep = '0;
  logic [CNT_W-1:0]  io_gap_cycle = '0;
  logic              io_busy;
  logic              io_done;
  logic [CNT_W-1:0]  io_sent_pkts;

  pkg_gen_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) dif ();

  pkg_gen #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_start     (io_start),
    .io_pkt_num   (io_pkt_num),
    .io_pkt_beats (io_pkt_beats),
    .io_last_keep (io_last_keep),
    .io_gap_cycle (io_gap_cycle),
    .io_busy      (io_busy),
    .io_done      (io_done),
    .io_sent_pkts (io_sent_pkts),
    .io_data_out  (dif)
  );

  always #5 clock = ~clock;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    fire_cnt = 0;
  int    done_cnt = 0;
  int    last_fire_cyc = 0;
  int    done_cyc = 0;
  int    max_gap = 0;
  int    idle_run = 0;
  bit    seen_fire = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_b;
  logic [CNT_W-1:0] ts_prev = '0;
  logic [CNT_W-1:0] ts_last = '0;
  int    ready_mode = 0;
  int    bp_idx = 0;
  logic [3:0] bp_pat = 4'b1001;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Sink ready: constant high, or the 1,0,0,1 backpressure pattern.
  always @(posedge clock) begin
    #1;
    if (ready_mode == 1) begin
      dif.ready = bp_pat[bp_idx];
      bp_idx = (bp_idx + 1) % 4;
    end else begin
      dif.ready = 1'b1;
      bp_idx = 0;
    end
  end

  // Monitor: pops expected beats on every fire and tracks stalls, gaps and done pulses.
  always @(negedge clock) begin
    logic [DATA_W-1:0] got;
    beat_t e;
    cyc++;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (io_start && !io_busy) begin
        max_gap = 0;
        idle_run = 0;
        seen_fire = 1'b0;
      end
      if (prev_stall) begin
        chk(dif.valid && dif.bits_data == prev_b.data && dif.bits_keep == prev_b.keep
            && dif.bits_last == prev_b.last, "stall_stable",
            dif.bits_data[127:0], prev_b.data[127:0]);
      end
      if (dif.valid && dif.ready) begin
        fire_cnt++;
        last_fire_cyc = cyc;
        if (seen_fire && idle_run > max_gap) max_gap = idle_run;
        seen_fire = 1'b1;
        idle_run = 0;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", dif.bits_data[127:0], 128'd0);
        end else begin
          e = exp_q.pop_front();
          got = dif.bits_data;
`ifdef PKG_GEN_TIMESTAMP_EN
          if (e.first) begin
            ts_prev = ts_last;
            ts_last = got[95:64];
            got[95:64] = 32'd0;
          end
`endif
          chk(got == e.data, "beat_data", got[127:0], e.data[127:0]);
          chk({dif.bits_last, dif.bits_keep} == {e.last, e.keep}, "beat_last_keep",
              {63'd0, dif.bits_last, dif.bits_keep}, {63'd0, e.last, e.keep});
        end
      end else if (!dif.valid && io_busy) begin
        idle_run++;
      end
      prev_stall = dif.valid && !dif.ready;
      prev_b.data = dif.bits_data;
      prev_b.keep = dif.bits_keep;
      prev_b.last = dif.bits_last;
      if (io_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_run(input int n, input int beats, input logic [KEEP_W-1:0] lk);
    beat_t b;
    int eb;
    int s;
    eb = (beats == 0) ? 1 : beats;
    s = 0;
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < eb; k++) begin
        b.data = '0;
        b.data[31:0] = s;
        b.data[63:32] = p;
        b.last = (k == eb - 1);
        b.keep = b.last ? lk : {KEEP_W{1'b1}};
        b.first = (k == 0);
        exp_q.push_back(b);
        s++;
      end
    end
  endtask

  task automatic pulse_start(input int n, input int beats, input logic [KEEP_W-1:0] lk, input int gap);
    @(posedge clock);
    #1;
    io_pkt_num = n;
    io_pkt_beats = beats;
    io_last_keep = lk;
    io_gap_cycle = gap;
    io_start = 1'b1;
    @(posedge clock);
    #1;
    io_start = 1'b0;
  endtask

  task automatic run(input int n, input int beats, input logic [KEEP_W-1:0] lk, input int gap,
                     input bit chk_gap, input int exp_gap, input bit poke);
    int f0;
    int d0;
    int eb;
    eb = (beats == 0) ? 1 : beats;
    f0 = fire_cnt;
    d0 = done_cnt;
    push_run(n, beats, lk);
    pulse_start(n, beats, lk, gap);
    if (n > 0) chk(dif.valid == 1'b1, "first_valid_latency", {127'd0, dif.valid}, 128'd1);
    else       chk(io_busy == 1'b1 && dif.valid == 1'b0, "zero_pkt_busy", {126'd0, io_busy, dif.valid}, 128'd2);
    if (poke) begin
      repeat (2) @(posedge clock);
      pulse_start(5, 1, 64'h1, 0);
      chk(io_busy == 1'b1, "busy_during_poke", {127'd0, io_busy}, 128'd1);
    end
    for (int i = 0; i < 5000 && done_cnt == d0; i++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
    chk(done_cnt == d0 + 1, "done_pulse_count", done_cnt - d0, 128'd1);
    chk(fire_cnt - f0 == n * eb, "beat_count", fire_cnt - f0, n * eb);
    chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 128'd0);
    chk(io_sent_pkts == n, "sent_pkts", io_sent_pkts, n);
    chk(io_busy == 1'b0 && io_done == 1'b0, "idle_after_run", {126'd0, io_busy, io_done}, 128'd0);
    if (n > 0) chk(done_cyc == last_fire_cyc + 1, "done_after_last", done_cyc - last_fire_cyc, 128'd1);
    if (chk_gap) chk(max_gap == exp_gap, "idle_gap", max_gap, exp_gap);
    exp_q.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk(dif.valid == 1'b0 && dif.bits_last == 1'b0, "reset_valid_last",
        {126'd0, dif.valid, dif.bits_last}, 128'd0);
    chk(io_busy == 1'b0 && io_done == 1'b0, "reset_busy_done", {126'd0, io_busy, io_done}, 128'd0);
    chk(io_sent_pkts == 32'd0, "reset_sent", io_sent_pkts, 128'd0);
    chk(dif.bits_data == '0 && dif.bits_keep == '0, "reset_data_keep",
        dif.bits_data[127:0] | dif.bits_keep, 128'd0);
    reset_n = 1'b1;

    run(3, 2, 64'h0000_0000_0000_ffff, 0, 1'b1, 0, 1'b0);
    run(2, 1, 64'h0000_0000_0000_00ff, 10, 1'b1, 10, 1'b0);
    ready_mode = 1;
    run(2, 4, 64'h0000_0000_00ff_ffff, 0, 1'b1, 0, 1'b0);
    ready_mode = 0;
    run(0, 3, 64'h1, 0, 1'b0, 0, 1'b0);
    run(2, 0, 64'h0f0f_0000_0000_0003, 0, 1'b1, 0, 1'b0);
    run(2, 3, 64'h0000_0000_ffff_ffff, 4, 1'b1, 4, 1'b1);

    push_run(3, 4, 64'h3);
    pulse_start(3, 4, 64'h3, 0);
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk(dif.valid == 1'b0 && io_busy == 1'b0, "async_reset_drop", {126'd0, dif.valid, io_busy}, 128'd0);
    chk(io_sent_pkts == 32'd0, "async_reset_sent", io_sent_pkts, 128'd0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    run(1, 2, 64'h7, 0, 1'b0, 0, 1'b0);

`ifdef PKG_GEN_TIMESTAMP_EN
    run(2, 2, 64'hff, 5, 1'b1, 5, 1'b0);
    chk(ts_last - ts_prev == 32'd7, "timestamp_delta", ts_last - ts_prev, 128'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
